// File: rtl/regfile_panel.sv
// ============================================================================
// regfile_panel : switch-driven register-file demo for the simulator panel
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_panel #(
  parameter int NBITS     = 8,
  parameter int NREGS     = 32,
  parameter int NBITS_LCD = 64
) (
  input  logic                 clk_2,
  input  logic                 rst_n,
  input  logic [NBITS-1:0]     SWI,
  output logic [NBITS-1:0]     LED,
  output logic [NBITS-1:0]     SEG,
  output logic [NBITS-1:0]     lcd_registrador [0:NREGS-1],
  output logic [NBITS-1:0]     lcd_pc,
  output logic [NBITS-1:0]     lcd_WriteData,
  output logic                 lcd_RegWrite,
  output logic [NBITS_LCD-1:0] lcd_a,
  output logic [NBITS_LCD-1:0] lcd_b
);

  localparam int C_DW = NBITS - 3;
  localparam int C_PW = $clog2(NREGS);

  localparam logic [1:0] C_OP_LOAD   = 2'b00;
  localparam logic [1:0] C_OP_ADD    = 2'b01;
  localparam logic [1:0] C_OP_SETPTR = 2'b10;
  localparam logic [1:0] C_OP_ROTL   = 2'b11;

  logic [NBITS-1:0] s1_q, s2_q;
  logic             p_q;
  logic [NBITS-1:0] regs_q [0:NREGS-1];
  logic [NBITS-1:0] regs_d [0:NREGS-1];
  logic [C_PW-1:0]  ptr_q, ptr_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic             carry_q, carry_d;
  logic [NBITS-1:0] wdata_q, wdata_d;
  logic             regwrite_q, regwrite_d;
  logic [NBITS-2:0] lastop_q, lastop_d;

  logic             w_commit;
  logic [1:0]       w_op;
  logic [NBITS-1:0] w_data_ext;
  logic [NBITS-1:0] w_cur;
  logic [NBITS:0]   w_sum;
  logic [NBITS-1:0] w_wval;
  logic             w_write;

  assign w_commit   = s2_q[NBITS-1] & ~p_q;
  assign w_op       = s2_q[NBITS-2:NBITS-3];
  assign w_data_ext = NBITS'(s2_q[C_DW-1:0]);
  assign w_cur      = regs_q[ptr_q];
  assign w_sum      = {1'b0, w_cur} + {1'b0, w_data_ext};

  always_comb begin
    regs_d     = regs_q;
    ptr_d      = ptr_q;
    pc_d       = pc_q;
    carry_d    = carry_q;
    wdata_d    = wdata_q;
    regwrite_d = 1'b0;
    lastop_d   = lastop_q;
    w_wval     = w_data_ext;
    w_write    = 1'b0;

    if (w_commit) begin
      pc_d     = pc_q + 1'b1;
      lastop_d = s2_q[NBITS-2:0];
      case (w_op)
        C_OP_LOAD: begin
          w_wval  = w_data_ext;
          w_write = 1'b1;
        end
        C_OP_ADD: begin
          w_wval  = w_sum[NBITS-1:0];
          carry_d = w_sum[NBITS];
          w_write = 1'b1;
        end
        C_OP_SETPTR: begin
          ptr_d = w_data_ext[C_PW-1:0];
        end
        C_OP_ROTL: begin
          w_wval  = {w_cur[NBITS-2:0], w_cur[NBITS-1]};
          w_write = 1'b1;
        end
        default: ;
      endcase
    end

    // Writes aimed at reg 0 still strobe and report the would-be value.
    if (w_write) begin
      regwrite_d     = 1'b1;
      wdata_d        = w_wval;
      regs_d[ptr_q]  = w_wval;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      p_q        <= 1'b0;
      ptr_q      <= '0;
      pc_q       <= '0;
      carry_q    <= 1'b0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
      lastop_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      s1_q       <= SWI;
      s2_q       <= s1_q;
      p_q        <= s2_q[NBITS-1];
      ptr_q      <= ptr_d;
      pc_q       <= pc_d;
      carry_q    <= carry_d;
      wdata_q    <= wdata_d;
      regwrite_q <= regwrite_d;
      lastop_q   <= lastop_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    LED           = w_cur;
    SEG           = '0;
    SEG[6:0]      = seg7(w_cur[3:0]);
    SEG[7]        = carry_q;
    lcd_pc        = pc_q;
    lcd_WriteData = wdata_q;
    lcd_RegWrite  = regwrite_q;
    lcd_a         = '0;
    lcd_a[C_PW+NBITS-1:0] = {ptr_q, w_cur};
    lcd_b         = '0;
    lcd_b[NBITS-2:0] = lastop_q;
    for (int i = 0; i < NREGS; i++) lcd_registrador[i] = regs_q[i];
  end

endmodule

`default_nettype wire
